bias_add_relu_layer17: RTL and testbench

Post-accumulation stage for layer 17: takes the 16 parallel 18-bit channel sums from the adder trees, adds the per-channel bias of the currently selected 16-channel group, applies saturation and optional ReLU, and emits the results with a valid/ready handshake. It drives the group select that picks one of the four 16-wide constant bias banks covering the 64 output channels, and sits between the adder trees and the next layer's input buffer.

---
 rtl/bias_add_relu_layer17.sv | 115 +++++++++++
 tb/tb_bias_add_relu_layer17.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_add_relu_layer17.sv
// Post-accumulation stage for layer 17: per-channel bias add, signed saturation
// to 18 bits and optional ReLU, in two register stages under a global stall.
`timescale 1ns/1ps
module bias_add_relu_layer17 #(
   parameter int N_adder_tree = 16,
   parameter int N_GROUPS     = 4,
   parameter int RELU_EN      = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_adder_tree*18-1:0] in_data,
   output logic [1:0]                 group_sel,
   input  logic [N_adder_tree*18-1:0] bias_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_adder_tree*18-1:0] out_data,
   output logic [1:0]                 out_group
);
   localparam int W  = 18;
   localparam int DW = N_adder_tree * W;

   // Handshake: a beat moves on a rising edge where valid and ready are both 1;
   // in_ready depends only on out_valid/out_ready, never on in_valid.
   logic                          adv;
   logic                          accept;
   logic [1:0]                    grp_q, grp_d;
   logic                          s1_valid_q, s1_valid_d;
   logic [1:0]                    s1_tag_q, s1_tag_d;
   logic [N_adder_tree-1:0][W:0]  s1_sum_q, s1_sum_d;
   logic                          s2_valid_q, s2_valid_d;
   logic [1:0]                    s2_tag_q, s2_tag_d;
   logic [DW-1:0]                 s2_data_q, s2_data_d;
   logic [W:0]                    wide;
   logic [W-1:0]                  res;
   logic [W-1:0]                  a_k;
   logic [W-1:0]                  b_k;

   always_comb begin
      adv        = !s2_valid_q || out_ready;
      accept     = in_valid && adv;
      grp_d      = grp_q;
      s1_valid_d = s1_valid_q;
      s1_tag_d   = s1_tag_q;
      s1_sum_d   = s1_sum_q;
      s2_valid_d = s2_valid_q;
      s2_tag_d   = s2_tag_q;
      s2_data_d  = s2_data_q;
      wide       = '0;
      res        = '0;
      a_k        = '0;
      b_k        = '0;

      if (clear)
         grp_d = '0;
      else if (accept)
         grp_d = (grp_q == 2'(N_GROUPS - 1)) ? 2'd0 : grp_q + 2'd1;

      if (adv) begin
         s1_valid_d = in_valid && !clear;
         s1_tag_d   = grp_q;
         s2_valid_d = s1_valid_q;
         s2_tag_d   = s1_tag_q;
         for (int k = 0; k < N_adder_tree; k++) begin
            a_k         = in_data[k*W +: W];
            b_k         = bias_in[k*W +: W];
            s1_sum_d[k] = {a_k[W-1], a_k} + {b_k[W-1], b_k};

            // Overflow shows as the two top bits of the 19-bit sum disagreeing.
            wide = s1_sum_q[k];
            if (wide[W] != wide[W-1])
               res = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else
               res = wide[W-1:0];
            if (RELU_EN != 0 && res[W-1])
               res = '0;
            s2_data_d[k*W +: W] = res;
         end
      end

      if (clear) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_sum_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_tag_q   <= '0;
         s2_data_q  <= '0;
      end else begin
         grp_q      <= grp_d;
         s1_valid_q <= s1_valid_d;
         s1_tag_q   <= s1_tag_d;
         s1_sum_q   <= s1_sum_d;
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
         s2_data_q  <= s2_data_d;
      end
   end

   assign in_ready  = adv;
   assign group_sel = grp_q;
   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_group = s2_tag_q;

endmodule

// File: tb/tb_bias_add_relu_layer17.sv
// Bench for bias_add_relu_layer17: two instances (ReLU on/off) share stimulus;
// expected results come from an integer model of bias add, clamp and ReLU.
`timescale 1ns/1ps
module tb_bias_add_relu_layer17;
   localparam int N  = 16;
   localparam int W  = 18;
   localparam int DW = N * W;
   localparam int EW = DW + 2;

   logic          clk = 1'b0;
   logic          rst, clear, in_valid, out_ready;
   logic [DW-1:0] in_data, bias_in;
   logic          in_ready1, in_ready0, ov1, ov0;
   logic [1:0]    gs1, gs0, og1, og0;
   logic [DW-1:0] od1, od0;

   logic signed [W-1:0] bank [4][16];
   logic [EW-1:0] exp_q1[$];
   logic [EW-1:0] exp_q0[$];
   int n_checks = 0;
   int n_pass   = 0;
   int grp_m    = 0;
   bit rand_bp  = 1'b0;

   always #5 clk = ~clk;

   bias_add_relu_layer17 #(.N_adder_tree(N), .N_GROUPS(4), .RELU_EN(1)) dut_r1 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .group_sel(gs1), .bias_in(bias_in), .out_valid(ov1),
      .out_ready(out_ready), .out_data(od1), .out_group(og1));

   bias_add_relu_layer17 #(.N_adder_tree(N), .N_GROUPS(4), .RELU_EN(0)) dut_r0 (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .group_sel(gs0), .bias_in(bias_in), .out_valid(ov0),
      .out_ready(out_ready), .out_data(od0), .out_group(og0));

   // Constant bias banks, looked up combinationally from the selected group.
   always_comb begin
      bias_in = '0;
      for (int ch = 0; ch < N; ch++)
         bias_in[ch*W +: W] = bank[gs1][ch];
   end

   task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
   endtask

   function automatic logic [EW-1:0] model(input logic [DW-1:0] d, input int g, input bit relu);
      logic [DW-1:0] r;
      logic signed [W-1:0] a;
      int s;
      r = '0;
      for (int ch = 0; ch < N; ch++) begin
         a = d[ch*W +: W];
         s = int'(a) + int'(bank[g][ch]);
         if (s > 131071) s = 131071;
         else if (s < -131072) s = -131072;
         if (relu && s < 0) s = 0;
         r[ch*W +: W] = s[W-1:0];
      end
      return {g[1:0], r};
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] r;
      r = '0;
      for (int ch = 0; ch < N; ch++) r[ch*W +: W] = W'($urandom);
      return r;
   endfunction

   task automatic send(input logic [DW-1:0] d, output int waited);
      bit done;
      done   = 1'b0;
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (!done) begin
         #1;
         if (in_ready1) begin
            chk("group_sel", EW'(gs1), EW'(grp_m));
            exp_q1.push_back(model(d, grp_m, 1'b1));
            exp_q0.push_back(model(d, grp_m, 1'b0));
            grp_m = (grp_m + 1) % 4;
            done  = 1'b1;
         end else if (waited >= 100) begin
            chk("send_timeout", EW'(0), EW'(1));
            done = 1'b1;
         end
         @(posedge clk);
         if (!done) begin
            @(negedge clk);
            waited++;
         end
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      grp_m = 0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q1.size() != 0 || exp_q0.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      #3;
      chk("drain", EW'(exp_q1.size() + exp_q0.size()), EW'(0));
   endtask

   // Monitor: any presented result must match the queue head; popped on transfer.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (ov1) begin
               if (exp_q1.size() == 0) chk("r1_unexpected", EW'(1), EW'(0));
               else begin
                  chk("r1_out", {og1, od1}, exp_q1[0]);
                  if (out_ready) void'(exp_q1.pop_front());
               end
            end
            if (ov0) begin
               if (exp_q0.size() == 0) chk("r0_unexpected", EW'(1), EW'(0));
               else begin
                  chk("r0_out", {og0, od0}, exp_q0[0]);
                  if (out_ready) void'(exp_q0.pop_front());
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      logic [DW-1:0] b;
      int w;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      for (int g = 0; g < 4; g++)
         for (int ch = 0; ch < N; ch++) bank[g][ch] = W'($urandom);
      bank[0][0] = -18'sd11220;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", EW'(in_ready1), EW'(1));
      chk("rst_out_valid", EW'({ov1, ov0}), EW'(0));
      chk("rst_out_data", EW'(od1 | od0), EW'(0));
      chk("rst_out_group", EW'({og1, og0}), EW'(0));
      chk("rst_group_sel", EW'({gs1, gs0}), EW'(0));
      rst = 1'b0;

      // 20000 + (-11220) = 8780, with latency check
      b = rand_beat(); b[W-1:0] = 18'd20000;
      send(b, w);
      #1 in_valid = 1'b0;
      @(negedge clk); #3 chk("lat_first_edge", EW'(ov1), EW'(0));
      @(negedge clk); #3 chk("lat_second_edge", EW'(ov1), EW'(1));
      drain();

      // 5000 - 11220 -> 0 with ReLU, -6220 without
      pulse_clear();
      b = rand_beat(); b[W-1:0] = 18'd5000;
      send(b, w); idle(); drain();

      // Saturation both ways
      pulse_clear();
      bank[0][0] = 18'sd1000;
      b = rand_beat(); b[W-1:0] = 18'h1FFFF;
      send(b, w); idle(); drain();
      pulse_clear();
      bank[0][0] = -18'sd11220;
      b = rand_beat(); b[W-1:0] = 18'h20000;
      send(b, w); idle(); drain();

      // Nine back-to-back beats: groups 0..3,0..3,0 at one per cycle
      pulse_clear();
      for (int i = 0; i < 9; i++) begin
         send(rand_beat(), w);
         chk("b2b_wait", EW'(w), EW'(0));
      end
      idle(); drain();

      // Backpressure with in_valid held high
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(rand_beat(), w);
            idle();
         end
         begin
            repeat (6) @(negedge clk);
            #3 chk("stall_in_ready", EW'(in_ready1), EW'(0));
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Random traffic with random backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         send(rand_beat(), w);
      end
      idle();
      @(negedge clk);
      #1 rand_bp = 1'b0;
      out_ready = 1'b1;
      drain();

      // Clear mid-stream after two accepted beats
      send(rand_beat(), w);
      send(rand_beat(), w);
      @(negedge clk);
      in_data = rand_beat();
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      in_valid = 1'b0;
      exp_q1.delete(); exp_q0.delete();
      grp_m = 0;
      @(negedge clk); #3;
      chk("clear_out_valid", EW'({ov1, ov0}), EW'(0));
      chk("clear_group_sel", EW'(gs1), EW'(0));
      send(rand_beat(), w); idle(); drain();

      // Asynchronous reset with a beat in flight
      send(rand_beat(), w);
      send(rand_beat(), w);
      #1 rst = 1'b1;
      in_valid = 1'b0;
      exp_q1.delete(); exp_q0.delete();
      grp_m = 0;
      #1 chk("arst_out_valid", EW'({ov1, ov0}), EW'(0));
      chk("arst_group_sel", EW'(gs1), EW'(0));
      @(negedge clk); #3 rst = 1'b0;
      send(rand_beat(), w); idle(); drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
